pixel_packer: RTL

PIXEL_PACKER -- requirements
Module: pixel_packer

---
 rtl/pixel_packer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pixel_packer.sv
// Packs a BMP-ordered byte stream (B,G,R per pixel, padded rows) into 24-bit pixels
// with x/y coordinates, sync flags and a per-frame completion count.
module pixel_packer #(
  parameter int LOC_SIZE   = 16,
  parameter int PIXEL_SIZE = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [LOC_SIZE-1:0]   width,
  input  logic [LOC_SIZE-1:0]   height,
  input  logic [1:0]            padding,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  pix_ready,
  output logic                  pix_valid,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic [LOC_SIZE-1:0]   x,
  output logic [LOC_SIZE-1:0]   y,
  output logic                  hsync,
  output logic                  vsync,
  output logic [LOC_SIZE-1:0]   frame,
  output logic                  frame_done
);

  typedef enum logic [1:0] {B0, B1, B2, PAD} state_e;

  state_e                state_q;
  logic [7:0]            byte0_q, byte1_q;
  logic [LOC_SIZE-1:0]   width_q, height_q, col_q, row_q, frame_q, x_q, y_q;
  logic [1:0]            padding_q, padCnt_q;
  logic                  start_q, pixValid_q, hsync_q, vsync_q, last_q;
  logic [PIXEL_SIZE-1:0] pixData_q;

  logic                  xfer, load, accept, rowEnd, frameEnd, geomOk;
  logic [PIXEL_SIZE-1:0] pixData_d;

  // While start_q is set the geometry has not been captured yet, so no bytes are taken.
  always_comb begin
    byte_ready = 1'b0;
    if (en) begin
      case (state_q)
        B0:      byte_ready = !start_q;
        B2:      byte_ready = !pixValid_q || pix_ready;
        default: byte_ready = 1'b1;
      endcase
    end
  end

  assign geomOk    = (width != '0) && (height != '0);
  assign xfer      = byte_valid && byte_ready;
  assign load      = xfer && (state_q == B2);
  assign accept    = en && pixValid_q && pix_ready;
  assign rowEnd    = (col_q == width_q - LOC_SIZE'(1));
  assign frameEnd  = rowEnd && (row_q == height_q - LOC_SIZE'(1));
  assign pixData_d = PIXEL_SIZE'({byte_data, byte1_q, byte0_q});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= B0;
      byte0_q    <= '0;
      byte1_q    <= '0;
      width_q    <= '0;
      height_q   <= '0;
      padding_q  <= '0;
      padCnt_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      frame_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      start_q    <= 1'b1;
      pixValid_q <= 1'b0;
      pixData_q  <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      if (load) begin
        pixValid_q <= 1'b1;
        pixData_q  <= pixData_d;
        x_q        <= col_q;
        y_q        <= row_q;
        hsync_q    <= (col_q == '0);
        vsync_q    <= (col_q == '0) && (row_q == '0);
        last_q     <= frameEnd;
      end else if (accept) begin
        pixValid_q <= 1'b0;
      end

      // last_q still describes the pixel leaving the output register on this edge.
      if (accept && last_q) begin
        frame_q <= frame_q + LOC_SIZE'(1);
      end

      if (en) begin
        case (state_q)
          B0: begin
            if (start_q) begin
              if (geomOk) begin
                width_q   <= width;
                height_q  <= height;
                padding_q <= padding;
                start_q   <= 1'b0;
              end
            end else if (xfer) begin
              byte0_q <= byte_data;
              state_q <= B1;
            end
          end
          B1: begin
            if (xfer) begin
              byte1_q <= byte_data;
              state_q <= B2;
            end
          end
          B2: begin
            if (xfer) begin
              if (rowEnd) begin
                col_q    <= '0;
                padCnt_q <= '0;
                state_q  <= (padding_q != 2'd0) ? PAD : B0;
                if (frameEnd) begin
                  row_q   <= '0;
                  start_q <= 1'b1;
                end else begin
                  row_q <= row_q + LOC_SIZE'(1);
                end
              end else begin
                col_q   <= col_q + LOC_SIZE'(1);
                state_q <= B0;
              end
            end
          end
          PAD: begin
            if (xfer) begin
              padCnt_q <= padCnt_q + 2'd1;
              if (padCnt_q == padding_q - 2'd1) begin
                state_q <= B0;
              end
            end
          end
          default: state_q <= B0;
        endcase
      end
    end
  end

  assign pix_valid  = pixValid_q;
  assign pix_data   = pixData_q;
  assign x          = x_q;
  assign y          = y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame      = frame_q;
  assign frame_done = accept && last_q;

endmodule
